store_align: RTL
================

// Module: store_align
// PURPOSE
// Store-path counterpart of the load extractor. Takes a core store (address, rs2 data, funct3),
// computes byte-lane write enables, and lane-shifts the data for a word-wide data memory port.
// Misaligned SH/SW crossing a word boundary are split into two sequential word writes via a small FSM.
// Sits between the MEM stage and the DMEM/IO write port, with valid/ready on both sides.
// PARAMETERS
// ADDR_WIDTH  32  byte-address width; memory side uses word address ADDR_WIDTH-2 bits
// PORTS
// clk         in   1             rising-edge clock
// rst         in   1             synchronous, active-high reset
// req_valid   in   1             store request present
// req_ready   out  1             store request accepted when req_valid&&req_ready
// req_addr    in   ADDR_WIDTH    byte address
// req_data    in   32            store data (rs2), right-justified
// req_funct3  in   3             FNC_SB=000, FNC_SH=001, FNC_SW=010
// mem_valid   out  1             write beat present
// mem_ready   in   1             memory accepts beat when mem_valid&&mem_ready
// mem_addr    out  ADDR_WIDTH-2  word address of beat
// mem_we      out  4             byte write enables, bit i -> mem_din[8i+7:8i]
// mem_din     out  32            lane-aligned write data
// done        out  1             high in the cycle the final beat of a store handshakes
// BEHAVIOUR
// - Size decode from funct3[1:0]: 00 byte, 01 half, 1x word. funct3[2] ignored.
// - Capture on accept: off=addr[1:0], wa=addr[ADDR_WIDTH-1:2];
//   mask8 = {4'b0, base} << off (base 0001/0011/1111); data64 = {32'b0, req_data} << (8*off).
// - split = |mask8[7:4]. Split cases: SH with off=3; SW with off!=0. SB never splits.
// - FSM states: IDLE, BEAT1, BEAT2.
//   IDLE:  req_ready=1; on accept, register fields and go to BEAT1.
//   BEAT1: mem_valid=1, mem_addr=wa, mem_we=mask8[3:0], mem_din=data64[31:0].
//          On mem_ready: go to BEAT2 if split, else assert done and go to IDLE.
//   BEAT2: mem_valid=1, mem_addr=wa+1 (wraps mod 2^(ADDR_WIDTH-2)), mem_we=mask8[7:4],
//          mem_din=data64[63:32]. On mem_ready: assert done, go to IDLE.
// - req_ready=0 in BEAT1/BEAT2; req_valid in these states is ignored, not queued.
// - Latency: accept at cycle N gives first mem_valid at N+1. Minimum 2 cycles per aligned store,
//   3 cycles per split store.
// - Stall: while mem_valid && !mem_ready, mem_addr/mem_we/mem_din are held stable.
// - When mem_valid=0: mem_we=4'b0000, mem_din=0, mem_addr=0.
// - Bytes of mem_din outside mem_we are 0.
// - Reset values: state=IDLE, req_ready=1, mem_valid=0, mem_we=0, mem_addr=0, mem_din=0, done=0.
// - Reset mid-store, from any state: next cycle is IDLE. A pending second beat is never issued.
//   Reset has priority over a same-cycle mem_ready or req_valid.
// - No combinational path from req_* to mem_*. done and the state advance depend
//   combinationally on mem_ready.
// TESTING
// 1. SB 0x1003, data 0xAABBCCDD -> one beat: addr 0x400, we 1000, din 0xDD000000; done.
// 2. SH 0x1002, data 0x00001234 -> one beat: addr 0x400, we 1100, din 0x12340000.
// 3. SW 0x1001, data 0x11223344 -> beat1: addr 0x400, we 1110, din 0x22334400;
//    beat2: addr 0x401, we 0001, din 0x00000011; done only on beat2.
// 4. SW 0xFFFFFFFE, data 0x11223344 -> beat1: addr 0x3FFFFFFF, we 1100, din 0x33440000;
//    beat2: addr 0x0, we 0011, din 0x00001122 (wrap).
// 5. Hold mem_ready=0 for 3 cycles in BEAT1 and pulse req_valid -> outputs stable, req_ready=0,
//    the new request is never accepted.
// 6. Assert rst during a stalled BEAT2 -> next cycle: mem_valid=0, mem_we=0, req_ready=1, done=0.

Source files
------------

// File: rtl/store_align.sv
// Store lane aligner: turns a core store into one or two byte-enabled word writes.
// Stores that cross a word boundary are issued as two sequential beats.
module store_align #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_funct3,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_din,
  output logic                  done
);

  localparam int unsigned WAW = ADDR_WIDTH - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT1 = 2'd1;
  localparam logic [1:0] BEAT2 = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [WAW-1:0] wa_q;
  logic [7:0]     mask_q;
  logic [63:0]    data_q;

  logic [3:0]     base;
  logic [31:0]    data_m;
  logic [7:0]     mask_new;
  logic [63:0]    data_new;
  logic [WAW-1:0] wa_inc;
  logic           split;
  logic           accept;
  logic           unused_funct3;

  // funct3[2] selects sign handling on loads only; stores ignore it.
  assign unused_funct3 = req_funct3[2];

  always_comb begin
    base = 4'b1111;
    unique case (req_funct3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
  end

  // Clear bytes above the store size so lanes outside mem_we carry zero.
  assign data_m   = req_data & {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
  assign mask_new = {4'b0000, base} << req_addr[1:0];
  assign data_new = {32'h0, data_m} << {req_addr[1:0], 3'b000};

  assign split  = |mask_q[7:4];
  assign wa_inc = wa_q + {{(WAW-1){1'b0}}, 1'b1};
  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BEAT1;
      BEAT1:   if (mem_ready) state_d = split ? BEAT2 : IDLE;
      BEAT2:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so req_* never reaches mem_* combinationally.
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_we    = 4'b0000;
    mem_din   = 32'h0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = wa_q;
        mem_we    = mask_q[3:0];
        mem_din   = data_q[31:0];
        done      = mem_ready && !split;
      end
      BEAT2: begin
        mem_valid = 1'b1;
        mem_addr  = wa_inc;
        mem_we    = mask_q[7:4];
        mem_din   = data_q[63:32];
        done      = mem_ready;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wa_q    <= '0;
      mask_q  <= 8'h00;
      data_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wa_q   <= req_addr[ADDR_WIDTH-1:2];
        mask_q <= mask_new;
        data_q <= data_new;
      end
    end
  end

endmodule
